// File: rtl/instr_encoder_if.sv
// Request/response bundle of the instruction encoder.
// Valid/ready: a request or a word transfers on a rising edge where valid && ready; valid must not depend on ready.
interface instr_encoder_if #(
  parameter int DEPTH = 4
) ();
  localparam int LW = $clog2(DEPTH) + 1;

  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_cls;
  logic [2:0]    in_sub;
  logic [4:0]    in_rs;
  logic [4:0]    in_rt;
  logic [4:0]    in_rd;
  logic [4:0]    in_shamt;
  logic [15:0]   in_imm;
  logic [25:0]   in_target;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_addr;
  logic [LW-1:0] level;
  logic          err;

  modport master (
    output flush, in_valid, in_cls, in_sub, in_rs, in_rt, in_rd, in_shamt,
           in_imm, in_target, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, level, err
  );

  modport slave (
    input  flush, in_valid, in_cls, in_sub, in_rs, in_rt, in_rd, in_shamt,
           in_imm, in_target, out_ready,
    output in_ready, out_valid, out_instr, out_addr, level, err
  );
endinterface

// File: rtl/instr_encoder.sv
// MIPS-subset instruction encoder: packs class/sub/field requests into 32-bit words, tags them with a
// running byte address and buffers them in a FIFO. Define ENC_ILLEGAL_CHK_EN to drop illegal requests and flag err.
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst_n,
  instr_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [2:0] CLS_ALU   = 3'd0;
  localparam logic [2:0] CLS_LOG   = 3'd1;
  localparam logic [2:0] CLS_DAT   = 3'd2;
  localparam logic [2:0] CLS_CON   = 3'd3;
  localparam logic [2:0] CLS_UNCON = 3'd4;
  localparam logic [2:0] CLS_COMP  = 3'd5;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [31:0]   addr_q;

  logic [5:0]    funct, opcode;
  logic          enc_legal;
  logic [31:0]   enc_word;
  logic          in_ready, accept, push, pop, clear;

  assign in_ready = level_q < LW'(DEPTH);
  assign clear    = !rst_n || bus.flush;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign pop      = (level_q != '0) && bus.out_ready;

`ifdef ENC_ILLEGAL_CHK_EN
  logic err_q;
  assign push    = accept && enc_legal;
  assign bus.err = err_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      err_q <= 1'b0;
    end else if (accept && !enc_legal) begin
      err_q <= 1'b1;
    end
  end
`else
  assign push    = accept;
  assign bus.err = 1'b0;
`endif

  always_comb begin
    funct     = '0;
    opcode    = '0;
    enc_legal = 1'b1;
    enc_word  = '0;
    case (bus.in_cls)
      CLS_ALU: begin
        case (bus.in_sub)
          3'd0:    funct = 6'b100000;
          3'd1:    funct = 6'b100010;
          3'd2:    funct = 6'b100001;
          3'd3:    funct = 6'b100011;
          3'd4:    funct = 6'b001000;
          3'd6:    funct = 6'b001001;
          default: enc_legal = 1'b0;
        endcase
      end
      CLS_LOG: begin
        case (bus.in_sub)
          3'd0:    funct = 6'b100100;
          3'd1:    funct = 6'b100101;
          3'd2:    funct = 6'b001100;
          3'd3:    funct = 6'b001101;
          3'd4:    funct = 6'b000000;
          3'd5:    funct = 6'b000010;
          default: enc_legal = 1'b0;
        endcase
      end
      CLS_COMP: begin
        case (bus.in_sub)
          3'd0:    funct = 6'b101010;
          3'd1:    funct = 6'b001010;
          default: enc_legal = 1'b0;
        endcase
      end
      CLS_DAT: begin
        case (bus.in_sub)
          3'd0:    opcode = 6'b100011;
          3'd1:    opcode = 6'b101011;
          default: enc_legal = 1'b0;
        endcase
      end
      CLS_CON: begin
        case (bus.in_sub)
          3'd0:    opcode = 6'b000100;
          3'd1:    opcode = 6'b000101;
          3'd2:    opcode = 6'b000111;
          3'd3:    opcode = 6'b011000;
          3'd4:    opcode = 6'b011001;
          3'd5:    opcode = 6'b010101;
          default: enc_legal = 1'b0;
        endcase
      end
      CLS_UNCON: begin
        case (bus.in_sub)
          3'd0:    opcode = 6'b000010;
          3'd1:    opcode = 6'b001000;
          3'd2:    opcode = 6'b000011;
          default: enc_legal = 1'b0;
        endcase
      end
      default: enc_legal = 1'b0;
    endcase

    case (bus.in_cls)
      CLS_ALU, CLS_LOG, CLS_COMP:
        enc_word = {6'b000000, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, funct};
      CLS_DAT, CLS_CON:
        enc_word = {opcode, bus.in_rs, bus.in_rt, bus.in_imm};
      CLS_UNCON:
        enc_word = (bus.in_sub == 3'd1) ? {opcode, bus.in_rs, 21'd0} : {opcode, bus.in_target};
      default: enc_word = '0;
    endcase
    // Illegal requests that still reach the FIFO carry an all-zero word.
    if (!enc_legal) enc_word = '0;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      addr_q   <= BASE_ADDR;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        addr_q   <= addr_q + 32'd4;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + LW'(push) - LW'(pop);
    end
  end

  // Storage is zeroed only by reset so the head reads 0 out of reset; a flush leaves stale data behind.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {enc_word, addr_q};
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (level_q != '0);
  assign bus.out_instr = mem_q[rd_ptr_q].instr;
  assign bus.out_addr  = mem_q[rd_ptr_q].addr;
  assign bus.level     = level_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: two instances (base 0 and base FFFF_FFF8) share one stimulus stream and
// are checked against a table-driven reference model through per-instance expected queues.
module tb_instr_encoder;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'hFFFF_FFF8;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        flush = 0, in_valid = 0, out_ready = 0;
  logic [2:0]  cls = 0, sub = 0;
  logic [4:0]  rs = 0, rt = 0, rd = 0, sh = 0;
  logic [15:0] imm = 0;
  logic [25:0] tgt = 0;
  bit          mon_en = 0, rnd_rdy = 0;

  instr_encoder_if #(.DEPTH(DEPTH)) bus0 ();
  instr_encoder_if #(.DEPTH(DEPTH)) bus1 ();

  assign bus0.flush = flush;     assign bus1.flush = flush;
  assign bus0.in_valid = in_valid; assign bus1.in_valid = in_valid;
  assign bus0.in_cls = cls;      assign bus1.in_cls = cls;
  assign bus0.in_sub = sub;      assign bus1.in_sub = sub;
  assign bus0.in_rs = rs;        assign bus1.in_rs = rs;
  assign bus0.in_rt = rt;        assign bus1.in_rt = rt;
  assign bus0.in_rd = rd;        assign bus1.in_rd = rd;
  assign bus0.in_shamt = sh;     assign bus1.in_shamt = sh;
  assign bus0.in_imm = imm;      assign bus1.in_imm = imm;
  assign bus0.in_target = tgt;   assign bus1.in_target = tgt;
  assign bus0.out_ready = out_ready; assign bus1.out_ready = out_ready;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // Reference tables: funct (R-type) or opcode (I/J-type) per sub, -1 = illegal
  int alu_f[8] = '{32, 34, 33, 35, 8, -1, 9, -1};
  int log_f[8] = '{36, 37, 12, 13, 0, 2, -1, -1};
  int cmp_f[8] = '{42, 10, -1, -1, -1, -1, -1, -1};
  int dat_o[8] = '{35, 43, -1, -1, -1, -1, -1, -1};
  int con_o[8] = '{4, 5, 7, 24, 25, 21, -1, -1};
  int unc_o[8] = '{2, 8, 3, -1, -1, -1, -1, -1};

  function automatic bit ref_word(input int c, s, a, b, d, h, i, t, output logic [31:0] w);
    longint v;
    int f;
    v = 0;
    f = -1;
    case (c)
      0, 1, 5: begin
        f = (c == 0) ? alu_f[s] : (c == 1) ? log_f[s] : cmp_f[s];
        if (f >= 0) v = longint'(a) * (2**21) + longint'(b) * (2**16) + longint'(d) * (2**11) + longint'(h) * 64 + f;
      end
      2, 3: begin
        f = (c == 2) ? dat_o[s] : con_o[s];
        if (f >= 0) v = longint'(f) * (2**26) + longint'(a) * (2**21) + longint'(b) * (2**16) + i;
      end
      4: begin
        f = unc_o[s];
        if (f >= 0) v = (s == 1) ? longint'(f) * (2**26) + longint'(a) * (2**21) : longint'(f) * (2**26) + t;
      end
      default: f = -1;
    endcase
    w = v[31:0];
    return f >= 0;
  endfunction

  // Scoreboard state
  logic [63:0] exp_q0[$];
  logic [63:0] exp_q1[$];
  int          m_level = 0;
  logic [31:0] m_addr0 = BASE0, m_addr1 = BASE1;
  logic        m_err = 0;
  int          n_cmp = 0, n_err = 0;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } dchk_t;
  dchk_t dir_q[$];
  dchk_t cur_d;

  // Reference model: applies the accept/push/pop rules at each rising edge
  always @(posedge clk) begin
    logic [31:0] w;
    bit ok, acc, psh, pp;
    if (!rst_n || flush) begin
      exp_q0.delete();
      exp_q1.delete();
      m_level = 0;
      m_addr0 = BASE0;
      m_addr1 = BASE1;
      m_err   = 0;
    end else begin
      pp  = (m_level > 0) && out_ready;
      acc = in_valid && (m_level < DEPTH);
      ok  = ref_word(int'(cls), int'(sub), int'(rs), int'(rt), int'(rd), int'(sh), int'(imm), int'(tgt), w);
`ifdef ENC_ILLEGAL_CHK_EN
      psh = acc && ok;
      if (acc && !ok) m_err = 1'b1;
`else
      psh = acc;
`endif
      if (psh) begin
        exp_q0.push_back({w, m_addr0});
        exp_q1.push_back({w, m_addr1});
        m_addr0 = m_addr0 + 32'd4;
        m_addr1 = m_addr1 + 32'd4;
      end
      m_level = m_level + int'(psh) - int'(pp);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pick(input int sel);
    case (sel)
      0: return 64'(bus0.in_ready);
      1: return 64'(bus0.out_valid);
      2: return 64'(bus0.level);
      3: return 64'(bus0.err);
      4: return 64'(bus0.out_instr);
      5: return 64'(bus0.out_addr);
      6: return 64'(bus1.out_addr);
      default: return 64'd1;
    endcase
  endfunction

  // Monitor: compares status and the FIFO head on the falling edge, pops on a consumed word
  always @(negedge clk) begin
    if (mon_en) begin
      check("level0", 64'(bus0.level), 64'(m_level));
      check("in_ready0", 64'(bus0.in_ready), 64'(m_level < DEPTH));
      check("out_valid0", 64'(bus0.out_valid), 64'(m_level != 0));
      check("err0", 64'(bus0.err), 64'(m_err));
      check("status1", {bus1.level, bus1.in_ready, bus1.out_valid, bus1.err},
            {bus0.level, bus0.in_ready, bus0.out_valid, bus0.err});
      if (bus0.out_valid) begin
        if (exp_q0.size() == 0) check("head0_empty_q", 64'd1, 64'd0);
        else begin
          check("head0", {bus0.out_instr, bus0.out_addr}, exp_q0[0]);
          if (out_ready) void'(exp_q0.pop_front());
        end
      end
      if (bus1.out_valid) begin
        if (exp_q1.size() == 0) check("head1_empty_q", 64'd1, 64'd0);
        else begin
          check("head1", {bus1.out_instr, bus1.out_addr}, exp_q1[0]);
          if (out_ready) void'(exp_q1.pop_front());
        end
      end
      while (dir_q.size() > 0) begin
        cur_d = dir_q.pop_front();
        check(cur_d.name, pick(cur_d.sel), cur_d.exp);
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic expect_sig(input string name, input int sel, input logic [63:0] exp);
    dchk_t d;
    d.name = name;
    d.sel  = sel;
    d.exp  = exp;
    dir_q.push_back(d);
  endtask

  task automatic set_req(input int c, s, a, b, d, h, i, t);
    cls = 3'(c); sub = 3'(s); rs = 5'(a); rt = 5'(b); rd = 5'(d); sh = 5'(h);
    imm = 16'(i); tgt = 26'(t);
  endtask

  task automatic send(input int c, s, a, b, d, h, i, t);
    bit acc;
    set_req(c, s, a, b, d, h, i, t);
    in_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) begin
      acc = bus0.in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!acc) expect_sig("send_timeout", 7, 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    step();
    mon_en = 1'b1;
    expect_sig("rst_in_ready", 0, 64'd1);
    expect_sig("rst_out_valid", 1, 64'd0);
    expect_sig("rst_level", 2, 64'd0);
    expect_sig("rst_err", 3, 64'd0);
    expect_sig("rst_out_instr", 4, 64'd0);
    expect_sig("rst_out_addr", 5, 64'd0);
    step();
    rst_n = 1'b1;

    // add r3, r1, r2
    out_ready = 1'b1;
    send(0, 0, 1, 2, 3, 0, 0, 0);
    expect_sig("add_valid", 1, 64'd1);
    expect_sig("add_instr", 4, 64'h0022_1820);
    expect_sig("add_addr", 5, 64'h0);
    expect_sig("add_addr_b1", 6, 64'hFFFF_FFF8);
    step();

    // lw / beq / j stream from a fresh address counter
    do_reset();
    send(2, 0, 29, 8, 0, 0, 16'h0004, 0);
    expect_sig("lw_instr", 4, 64'h8FA8_0004);
    expect_sig("lw_addr", 5, 64'h0);
    send(3, 0, 1, 2, 0, 0, 16'hFFFF, 0);
    expect_sig("beq_instr", 4, 64'h1022_FFFF);
    expect_sig("beq_addr", 5, 64'h4);
    expect_sig("beq_addr_b1", 6, 64'hFFFF_FFFC);
    send(4, 0, 0, 0, 0, 0, 0, 26'h000_0010);
    expect_sig("j_instr", 4, 64'h0800_0010);
    expect_sig("j_addr", 5, 64'h8);
    expect_sig("j_addr_b1", 6, 64'h0);
    step();

    // Fill to full with the consumer stalled, then drain
    do_reset();
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) send(0, n, n, n + 1, n + 2, 0, 0, 0);
    set_req(1, 1, 7, 8, 9, 0, 0, 0);
    in_valid = 1'b1;
    step();
    step();
    expect_sig("full_in_ready", 0, 64'd0);
    expect_sig("full_level", 2, 64'd4);
    in_valid = 1'b0;
    step();
    out_ready = 1'b1;
    send(1, 1, 7, 8, 9, 0, 0, 0);
    repeat (6) step();
    expect_sig("drain_level", 2, 64'd0);
    step();

    // Illegal request
    do_reset();
    out_ready = 1'b0;
    send(1, 7, 3, 4, 5, 6, 0, 0);
    send(0, 1, 1, 2, 3, 0, 0, 0);
`ifdef ENC_ILLEGAL_CHK_EN
    expect_sig("ill_err", 3, 64'd1);
    expect_sig("ill_level", 2, 64'd1);
    expect_sig("ill_head_instr", 4, 64'h0022_1822);
    expect_sig("ill_head_addr", 5, 64'h0);
`else
    expect_sig("ill_err", 3, 64'd0);
    expect_sig("ill_level", 2, 64'd2);
    expect_sig("ill_head_instr", 4, 64'h0);
    expect_sig("next_after_ill", 2, 64'd2);
`endif
    step();

    // Flush with a simultaneous request
    for (int n = 0; n < 3 - 2; n++) send(2, 1, 5, 6, 0, 0, 16'h0010, 0);
    flush = 1'b1;
    set_req(0, 0, 9, 9, 9, 0, 0, 0);
    in_valid = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    expect_sig("flush_level", 2, 64'd0);
    expect_sig("flush_valid", 1, 64'd0);
    expect_sig("flush_err", 3, 64'd0);
    step();
    send(0, 2, 1, 1, 1, 0, 0, 0);
    expect_sig("post_flush_addr", 5, 64'h0);
    expect_sig("post_flush_addr_b1", 6, 64'hFFFF_FFF8);
    expect_sig("post_flush_level", 2, 64'd1);
    step();

    // Randomized traffic with random back-pressure, flushes and resets
    rnd_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        flush = 1'b1;
        in_valid = 1'($urandom_range(0, 1));
        step();
        flush = 1'b0;
        in_valid = 1'b0;
      end else if (r < 3) begin
        do_reset();
      end else if (r < 15) begin
        step();
      end else begin
        send($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
             $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 65535),
             $urandom_range(0, 32'h3FF_FFFF));
      end
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (8) step();
    expect_sig("final_level", 2, 64'd0);
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
